// File: rtl/cpu_types_pkg.sv
// Shared types for the data-cache responder: word type, address breakdown and FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAG_W   = 26;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned BLKOFF_W = 1;

    typedef logic [WORD_W-1:0] word_t;

    // Byte address split as tag[31:6], idx[5:3], blkoff[2], bytoff[1:0].
    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [IDX_W-1:0]    idx;
        logic [BLKOFF_W-1:0] blkoff;
        logic [1:0]          bytoff;
    } dcachef_t;

    typedef enum logic [2:0] {
        StIdle,
        StWb0,
        StWb1,
        StFetch0,
        StFetch1,
        StFlush0,
        StFlush1,
        StDone
    } dstate_t;

    // Word address of one word of a block; byte offset is always 00 on the memory side.
    function automatic word_t blk_addr(input logic [TAG_W-1:0] tag,
                                       input logic [IDX_W-1:0] idx,
                                       input logic             blkoff);
        return {tag, idx, blkoff, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back data cache responder with two-word blocks.
// Serves MEM-stage loads/stores, fills and evicts over a single-word memory
// handshake, and flushes every dirty frame on halt.
module dcache_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS     = 8,
    parameter int unsigned BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    // Frame array; only valid/dirty are reset.
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [TAG_W-1:0] r_tag  [SETS];
    word_t            r_data [SETS][BLKWORDS];

    dstate_t          r_state;
    dstate_t          w_next;

    // Miss context captured in IDLE so the fill finishes even if the request goes away.
    logic [TAG_W-1:0] r_mtag;
    logic [IDX_W-1:0] r_midx;
    logic [IDX_W-1:0] r_fidx;

    dcachef_t         w_req;
    logic             w_req_any;
    logic             w_hit;
    logic             w_store_hit;
    logic             w_vic_dirty;
    logic             w_flush_last;
    logic             w_miss_start;
    logic             w_flush_start;
    logic             w_fidx_step;
    logic             w_fill_we;
    logic             w_fill_word;
    logic             w_flush_clr;
    logic             w_unused_bytoff;

    assign w_req           = dcachef_t'(dmemaddr);
    assign w_unused_bytoff = ^w_req.bytoff;
    assign w_req_any       = dmemREN | dmemWEN;
    assign w_hit           = ~RST & (r_state == StIdle) & w_req_any & r_valid[w_req.idx]
                             & (r_tag[w_req.idx] == w_req.tag);
    // Both enables high is a store.
    assign w_store_hit     = w_hit & dmemWEN;
    assign w_vic_dirty     = r_valid[w_req.idx] & r_dirty[w_req.idx];
    assign w_flush_last    = (r_fidx == IDX_W'(SETS - 1));
    assign w_fill_word     = (r_state == StFetch1);
    assign w_flush_clr     = ~RST & (r_state == StFlush1) & ~dwait;

    assign dhit     = w_hit;
    assign dmemload = w_hit ? r_data[w_req.idx][w_req.blkoff] : '0;

    // Next-state and memory-side outputs; reset forces every output to zero.
    always_comb begin
        w_next        = r_state;
        dREN          = 1'b0;
        dWEN          = 1'b0;
        daddr         = '0;
        dstore        = '0;
        flushed       = 1'b0;
        w_miss_start  = 1'b0;
        w_flush_start = 1'b0;
        w_fidx_step   = 1'b0;
        w_fill_we     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (halt) begin
                    w_flush_start = 1'b1;
                    w_next        = StFlush0;
                end else if (w_req_any && !w_hit) begin
                    w_miss_start = 1'b1;
                    w_next       = w_vic_dirty ? StWb0 : StFetch0;
                end
            end
            StWb0: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(r_tag[r_midx], r_midx, 1'b0);
                dstore = r_data[r_midx][0];
                if (!dwait) w_next = StWb1;
            end
            StWb1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(r_tag[r_midx], r_midx, 1'b1);
                dstore = r_data[r_midx][1];
                if (!dwait) w_next = StFetch0;
            end
            StFetch0: begin
                dREN  = 1'b1;
                daddr = blk_addr(r_mtag, r_midx, 1'b0);
                if (!dwait) begin
                    w_fill_we = 1'b1;
                    w_next    = StFetch1;
                end
            end
            StFetch1: begin
                dREN  = 1'b1;
                daddr = blk_addr(r_mtag, r_midx, 1'b1);
                if (!dwait) begin
                    w_fill_we = 1'b1;
                    w_next    = StIdle;
                end
            end
            StFlush0: begin
                if (r_dirty[r_fidx]) begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(r_tag[r_fidx], r_fidx, 1'b0);
                    dstore = r_data[r_fidx][0];
                    if (!dwait) w_next = StFlush1;
                end else begin
                    // Clean frame: move on without touching memory.
                    w_fidx_step = 1'b1;
                    if (w_flush_last) w_next = StDone;
                end
            end
            StFlush1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(r_tag[r_fidx], r_fidx, 1'b1);
                dstore = r_data[r_fidx][1];
                if (!dwait) begin
                    w_fidx_step = 1'b1;
                    w_next      = w_flush_last ? StDone : StFlush0;
                end
            end
            StDone: begin
                flushed = 1'b1;
            end
            default: begin
                w_next = StIdle;
            end
        endcase

        if (RST) begin
            dREN          = 1'b0;
            dWEN          = 1'b0;
            daddr         = '0;
            dstore        = '0;
            flushed       = 1'b0;
            w_miss_start  = 1'b0;
            w_flush_start = 1'b0;
            w_fidx_step   = 1'b0;
            w_fill_we     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= StIdle;
        else     r_state <= w_next;
    end

    // Capture tag/index of the missing request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtag <= '0;
            r_midx <= '0;
        end else if (w_miss_start) begin
            r_mtag <= w_req.tag;
            r_midx <= w_req.idx;
        end
    end

    // Flush frame counter.
    always_ff @(posedge CLK) begin
        if (RST)                r_fidx <= '0;
        else if (w_flush_start) r_fidx <= '0;
        else if (w_fidx_step)   r_fidx <= r_fidx + 1'b1;
    end

    // Valid/dirty: set by store hits and fills, cleared by flush write-back and reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_store_hit) r_dirty[w_req.idx] <= 1'b1;
            if (w_fill_we && w_fill_word) begin
                r_valid[r_midx] <= 1'b1;
                r_dirty[r_midx] <= 1'b0;
            end
            if (w_flush_clr) r_dirty[r_fidx] <= 1'b0;
        end
    end

    // Tag and data storage, not reset.
    always_ff @(posedge CLK) begin
        if (w_store_hit) r_data[w_req.idx][w_req.blkoff] <= dmemstore;
        if (w_fill_we) r_data[r_midx][w_fill_word] <= dload;
        if (w_fill_we && w_fill_word) r_tag[r_midx] <= r_mtag;
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: expected memory transfers are queued as
// stimulus is issued and popped when the DUT completes a transfer.
module tb_dcache_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload = 32'h0;
    logic        dwait = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [64:0] exp_q   [$];

    int          mem_lat = 2;
    int          cnt;
    bit          busy = 1'b0;
    logic [32:0] pend;
    logic [32:0] key;
    logic [66:0] cur;
    logic [66:0] snap;
    bit          snap_v = 1'b0;
    bit          last_edge_rst = 1'b1;
    logic [64:0] got_x;
    logic [64:0] exp_x;

    always #5 CLK = ~CLK;

    dcache_responder #(.SETS(8), .BLKWORDS(2)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .halt      (halt),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] refv(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back({1'b0, a, 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] a);
        exp_q.push_back({1'b1, a, refv(a)});
    endtask

    // Memory model: each transfer waits mem_lat cycles with dwait high, then completes.
    always @(negedge CLK) begin
        cur = {dREN, dWEN, dhit, daddr, dstore};
        if (snap_v && !last_edge_rst) check("hold_while_wait", 96'(cur), 96'(snap));
        if (!dhit) check("load_zero", 96'(dmemload), 96'(0));
        if (dREN || dWEN) begin
            check("one_rw", 96'(dREN & dWEN), 96'(0));
            key = {dWEN, daddr};
            if (!busy || key != pend) begin
                busy = 1'b1;
                pend = key;
                cnt  = mem_lat;
            end
            if (cnt == 0) begin
                dwait = 1'b0;
                dload = mem_rd(daddr);
                busy  = 1'b0;
            end else begin
                dwait = 1'b1;
                cnt--;
            end
        end else begin
            busy  = 1'b0;
            dwait = 1'b1;
        end
        snap_v = (dREN || dWEN) && dwait;
        snap   = cur;
    end

    // Transfer monitor: a transfer completes at an edge where dwait is low and no reset.
    always @(posedge CLK) begin
        last_edge_rst = RST;
        if (!RST && (dREN || dWEN) && !dwait) begin
            got_x = {dWEN, daddr, dWEN ? dstore : 32'h0};
            if (exp_q.size() == 0) begin
                check($sformatf("xfer_extra_%h", daddr), 96'(exp_q.size()), 96'(1));
            end else begin
                exp_x = exp_q.pop_front();
                check("xfer", 96'(got_x), 96'(exp_x));
            end
            if (dWEN) mem[daddr] = dstore;
        end
    end

    // One request: wait for dhit (bounded), check latency and load data, then release.
    task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] wdata, input int exp_lat, input string tag);
        int lat;
        bit got;
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemaddr  = a;
        dmemstore = wdata;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge CLK);
            if (dhit) got = 1'b1;
            else      lat++;
        end
        check({tag, "_hit"}, 96'(got), 96'(1));
        check({tag, "_lat"}, 96'(lat), 96'(exp_lat));
        if (got && !wen) check({tag, "_data"}, 96'(dmemload), 96'(refv(a)));
        @(posedge CLK);
        #1;
        if (wen && got) ref_mem[a] = wdata;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        check({tag, "_xq_empty"}, 96'(exp_q.size()), 96'(0));
    endtask

    initial begin
        int n;
        bit seen;
        RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0; halt = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_outputs", 96'({dhit, dmemload, dREN, dWEN, daddr, dstore, flushed}), 96'(0));
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_outputs", 96'({dhit, dmemload, dREN, dWEN, daddr, dstore, flushed}),
              96'(0));
        @(posedge CLK); #1;

        // Cold load: two reads, 1 + 2*(2+1) cycles to the hit.
        mem_lat = 2;
        push_rd(32'h40); push_rd(32'h44);
        access(1'b1, 1'b0, 32'h40, '0, 7, "cold_ld");
        access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 0, "st_hit");
        access(1'b1, 1'b0, 32'h44, '0, 0, "ld_after_st");

        // Dirty eviction with long memory latency: 4 transfers of 11 cycles each.
        mem_lat = 10;
        push_wr(32'h40); push_wr(32'h44); push_rd(32'h80); push_rd(32'h84);
        access(1'b1, 1'b0, 32'h84, '0, 45, "evict_ld");

        // Clean eviction back to the first tag: reads only.
        mem_lat = 2;
        push_rd(32'h40); push_rd(32'h44);
        access(1'b1, 1'b0, 32'h40, '0, 7, "clean_evict");
        access(1'b1, 1'b0, 32'h44, '0, 0, "wb_data_back");

        // Both enables high acts as a store.
        access(1'b1, 1'b1, 32'h40, 32'h1234_5678, 0, "both_st");
        access(1'b1, 1'b0, 32'h40, '0, 0, "both_ld");

        // Store miss to frame 5 fills, then stores on the hit.
        push_rd(32'h68); push_rd(32'h6C);
        access(1'b0, 1'b1, 32'h68, 32'hCAFE_F00D, 7, "st_miss");

        // Request dropped mid-fill: fill completes, store never applied.
        push_rd(32'hC8); push_rd(32'hCC);
        dmemWEN = 1'b1; dmemaddr = 32'hC8; dmemstore = 32'h5555_AAAA;
        repeat (2) @(posedge CLK);
        #1 dmemWEN = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        check("drop_xq_empty", 96'(exp_q.size()), 96'(0));
        @(posedge CLK); #1;
        access(1'b1, 1'b0, 32'hC8, '0, 0, "drop_ld");

        // Flush: frames 0 and 5 dirty, frame 1 clean.
        mem_lat = 1;
        push_wr(32'h40); push_wr(32'h44); push_wr(32'h68); push_wr(32'h6C);
        halt = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge CLK);
            if (flushed) seen = 1'b1;
            n++;
        end
        check("flush_done", 96'(seen), 96'(1));
        check("flush_xq_empty", 96'(exp_q.size()), 96'(0));
        dmemREN = 1'b1; dmemaddr = 32'hC8;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("flush_hold_%0d", i), 96'({flushed, dREN, dWEN, dhit}),
                  96'(4'b1000));
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; halt = 1'b0; RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("flush_rst_clear", 96'({flushed, dREN, dWEN, dhit}), 96'(0));
        @(posedge CLK); #1;

        // Reset during FETCH1: the second read is dropped, reload misses again.
        mem_lat = 2;
        push_rd(32'h40);
        dmemREN = 1'b1; dmemaddr = 32'h40;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge CLK);
            if (dREN && daddr == 32'h44) seen = 1'b1;
            n++;
        end
        check("reach_fetch1", 96'(seen), 96'(1));
        RST = 1'b1; dmemREN = 1'b0;
        #1;
        check("rst_mid_outputs", 96'({dhit, dREN, dWEN, daddr, dstore, flushed}), 96'(0));
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_idle", 96'({dREN, dWEN, dhit}), 96'(0));
        check("rst_mid_xq", 96'(exp_q.size()), 96'(0));
        @(posedge CLK); #1;
        push_rd(32'h40); push_rd(32'h44);
        access(1'b1, 1'b0, 32'h40, '0, 7, "reload_miss");

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
